// File: rtl/escalonador_matriz_if.sv
// Bundle between the two requesters, the sequencer and the LED-matrix decoder.
// req/ack: a requester holds req with a stable code until a one-cycle ack; err is valid only with ack.
interface escalonador_matriz_if #(
    parameter int COLS = 5
);
    logic            req1;
    logic [2:0]      code1;
    logic            req2;
    logic [2:0]      code2;
    logic            ack1;
    logic            ack2;
    logic            err1;
    logic            err2;
    logic [2:0]      out1;
    logic [2:0]      out2;
    logic [COLS-1:0] col;
    logic            colisao;
    logic            frame_end;
    logic            state_dbg;

    modport master (
        output req1, code1, req2, code2,
        input  ack1, ack2, err1, err2, out1, out2, col, colisao, frame_end, state_dbg
    );

    modport slave (
        input  req1, code1, req2, code2,
        output ack1, ack2, err1, err2, out1, out2, col, colisao, frame_end, state_dbg
    );
endinterface

// File: rtl/escalonador_matriz.sv
// Two-slot LED-matrix sequencer: validates codes, commits them on frame edges, scans columns.
// Optional blink of the collision loser is built when ESCALONADOR_MATRIZ_BLINK_EN is defined.
module escalonador_matriz #(
    parameter int DIV          = 4,
    parameter int COLS         = 5,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                clk,
    input  logic                rst,
    escalonador_matriz_if.slave bus
);
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int            CW         = $clog2(COLS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    if (DIV < 1 || COLS < 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("escalonador_matriz: illegal parameter values");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [CW-1:0]   r_col_idx;
    logic [CW-1:0]   w_col_idx_nxt;
    logic            w_frame_edge;
    logic [COLS-1:0] w_col;

    logic       r_pend1_v, r_pend2_v;
    logic [2:0] r_pend1, r_pend2;
    logic [2:0] r_out1, r_out2;
    logic       r_ack1, r_ack2;
    logic       r_err1, r_err2;
    logic       r_colisao;
    logic       r_frame_end;
    logic       r_ptr;

    logic       w_cap1, w_cap2;
    logic       w_ok1, w_ok2;
    logic [2:0] w_new1, w_new2;
    logic       w_hit;

    function automatic logic code_valid(input logic [2:0] c);
        return (c != 3'd0) && (c != 3'd2);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_col_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_col_idx <= w_col_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_col_idx_nxt = r_col_idx;
        w_frame_edge  = 1'b0;
        w_col         = '1;
        case (r_state)
            S_IDLE: w_state_nxt = S_SCAN;
            S_SCAN: begin
                w_col = ~(COLS'(1) << r_col_idx);
                if (r_presc == PRESC_LAST) begin
                    w_presc_nxt = '0;
                    if (r_col_idx == COL_LAST) begin
                        w_col_idx_nxt = '0;
                        w_frame_edge  = 1'b1;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A req during its own ack cycle is the tail of the request just served, not a new one.
    assign w_cap1 = bus.req1 && !r_pend1_v && !r_ack1;
    assign w_cap2 = bus.req2 && !r_pend2_v && !r_ack2;
    assign w_ok1  = w_cap1 && code_valid(bus.code1);
    assign w_ok2  = w_cap2 && code_valid(bus.code2);

    assign w_new1 = r_pend1_v ? r_pend1 : r_out1;
    assign w_new2 = r_pend2_v ? r_pend2 : r_out2;
    assign w_hit  = (w_new1 == w_new2) && (w_new1 != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend1_v   <= 1'b0;
            r_pend2_v   <= 1'b0;
            r_pend1     <= 3'd0;
            r_pend2     <= 3'd0;
            r_out1      <= 3'd0;
            r_out2      <= 3'd0;
            r_ack1      <= 1'b0;
            r_ack2      <= 1'b0;
            r_err1      <= 1'b0;
            r_err2      <= 1'b0;
            r_colisao   <= 1'b0;
            r_frame_end <= 1'b0;
            r_ptr       <= 1'b0;
        end else begin
            r_ack1      <= w_cap1;
            r_ack2      <= w_cap2;
            r_err1      <= w_cap1 && !w_ok1;
            r_err2      <= w_cap2 && !w_ok2;
            r_frame_end <= w_frame_edge;
            // r_ptr = 0 gives slot 1 priority; the other slot is blanked on a collision.
            if (w_frame_edge) begin
                r_pend1_v <= 1'b0;
                r_pend2_v <= 1'b0;
                r_out1    <= (w_hit && r_ptr)  ? 3'd0 : w_new1;
                r_out2    <= (w_hit && !r_ptr) ? 3'd0 : w_new2;
                r_colisao <= w_hit;
                if (w_hit) begin
                    r_ptr <= ~r_ptr;
                end
            end
            if (w_ok1) begin
                r_pend1_v <= 1'b1;
                r_pend1   <= bus.code1;
            end
            if (w_ok2) begin
                r_pend2_v <= 1'b1;
                r_pend2   <= bus.code2;
            end
        end
    end

`ifdef ESCALONADOR_MATRIZ_BLINK_EN
    localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    logic          r_loser2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt   <= '0;
            r_phase  <= 1'b0;
            r_loser2 <= 1'b1;
        end else if (w_frame_edge) begin
            if (r_fcnt == FRAME_LAST) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            if (w_hit) begin
                r_loser2 <= ~r_ptr;
            end
        end
    end

    assign bus.out1 = (r_phase && !r_loser2) ? 3'd0 : r_out1;
    assign bus.out2 = (r_phase && r_loser2)  ? 3'd0 : r_out2;
`else
    assign bus.out1 = r_out1;
    assign bus.out2 = r_out2;
`endif

    assign bus.ack1      = r_ack1;
    assign bus.ack2      = r_ack2;
    assign bus.err1      = r_err1;
    assign bus.err2      = r_err2;
    assign bus.col       = w_col;
    assign bus.colisao   = r_colisao;
    assign bus.frame_end = r_frame_end;
    assign bus.state_dbg = (r_state == S_SCAN);
endmodule

// File: tb/tb_escalonador_matriz.sv
// Bench for escalonador_matriz: frame-arithmetic reference model checked every cycle,
// plus directed handshake/commit/collision/reset scenarios with literal expectations.
module tb_escalonador_matriz;
    localparam int DIV   = 4;
    localparam int COLS  = 5;
    localparam int BF    = 8;
    localparam int FRAME = DIV * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    escalonador_matriz_if #(.COLS(COLS)) bus ();

    escalonador_matriz #(.DIV(DIV), .COLS(COLS), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference model: column and frame position follow from the count of scan cycles.
    bit         m_ok = 1'b0;
    bit         m_scan;
    int         m_n;
    bit         m_pv[2];
    logic [2:0] m_pc[2];
    logic [2:0] m_out[2];
    bit         m_ack[2];
    bit         m_err[2];
    bit         m_coll, m_fe, m_ptr;
    int         m_frames;
    int         m_loser;

    always @(posedge clk) begin : model
        bit         at_edge;
        bit         hit;
        bit         cap[2];
        bit         rq[2];
        logic [2:0] cd[2];
        logic [2:0] nv[2];
        rq[0] = bus.req1;
        rq[1] = bus.req2;
        cd[0] = bus.code1;
        cd[1] = bus.code2;
        if (rst) begin
            m_ok = 1'b1; m_scan = 1'b0; m_n = 0; m_coll = 1'b0; m_fe = 1'b0;
            m_ptr = 1'b0; m_frames = 0; m_loser = 1;
            for (int s = 0; s < 2; s++) begin
                m_pv[s] = 1'b0; m_pc[s] = 3'd0; m_out[s] = 3'd0; m_ack[s] = 1'b0; m_err[s] = 1'b0;
            end
        end else begin
            at_edge = m_scan && (m_n % FRAME == FRAME - 1);
            for (int s = 0; s < 2; s++) cap[s] = rq[s] && !m_pv[s] && !m_ack[s];
            if (at_edge) begin
                for (int s = 0; s < 2; s++) begin
                    nv[s]   = m_pv[s] ? m_pc[s] : m_out[s];
                    m_pv[s] = 1'b0;
                end
                hit = (nv[0] == nv[1]) && (nv[0] != 3'd0);
                if (hit) begin
                    m_loser     = m_ptr ? 0 : 1;
                    nv[m_loser] = 3'd0;
                    m_ptr       = !m_ptr;
                end
                m_coll   = hit;
                m_out[0] = nv[0];
                m_out[1] = nv[1];
                m_frames++;
            end
            for (int s = 0; s < 2; s++) begin
                m_ack[s] = cap[s];
                m_err[s] = cap[s] && (cd[s] == 3'd0 || cd[s] == 3'd2);
                if (cap[s] && !m_err[s]) begin
                    m_pv[s] = 1'b1;
                    m_pc[s] = cd[s];
                end
            end
            m_fe = at_edge;
            if (m_scan) m_n++;
            m_scan = 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        logic [COLS-1:0] one;
        logic [COLS-1:0] exp_col;
        logic [2:0]      exp_o[2];
        if (m_ok) begin
            one     = 1;
            exp_col = m_scan ? ~(one << ((m_n / DIV) % COLS)) : '1;
            exp_o[0] = m_out[0];
            exp_o[1] = m_out[1];
`ifdef ESCALONADOR_MATRIZ_BLINK_EN
            if ((m_frames / BF) % 2 == 1) exp_o[m_loser] = 3'd0;
`endif
            chk("col", bus.col, exp_col);
            chk("state", bus.state_dbg, m_scan);
            chk("out1", bus.out1, exp_o[0]);
            chk("out2", bus.out2, exp_o[1]);
            chk("ack1", bus.ack1, m_ack[0]);
            chk("ack2", bus.ack2, m_ack[1]);
            if (m_ack[0]) chk("err1", bus.err1, m_err[0]);
            if (m_ack[1]) chk("err2", bus.err2, m_err[1]);
            chk("colisao", bus.colisao, m_coll);
            chk("frame_end", bus.frame_end, m_fe);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int slot, input logic [2:0] c, output logic e);
        bit got;
        got = 1'b0;
        e   = 1'b0;
        if (slot == 1) begin bus.req1 = 1'b1; bus.code1 = c; end
        else           begin bus.req2 = 1'b1; bus.code2 = c; end
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if ((slot == 1) ? bus.ack1 : bus.ack2) begin
                got = 1'b1;
                e   = (slot == 1) ? bus.err1 : bus.err2;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout slot%0d: got no ack, required ack within 100 cycles", slot);
        end
        @(posedge clk);
        #1;
        if (slot == 1) bus.req1 = 1'b0;
        else           bus.req2 = 1'b0;
    endtask

    task automatic wait_fe();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            @(negedge clk);
            seen = bus.frame_end;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL fe_timeout: got no frame_end, required one within %0d cycles", 3 * FRAME);
        end
    endtask

    initial begin : directed
        logic e;
        int   cnt;
        bit   seen;
        bus.req1 = 1'b0; bus.req2 = 1'b0; bus.code1 = 3'd0; bus.code2 = 3'd0;

        repeat (3) @(negedge clk);
        chk("rst_col", bus.col, 5'b11111);
        chk("rst_out1", bus.out1, 3'd0);
        chk("rst_fe", bus.frame_end, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_col", bus.col, 5'b11110);
        repeat (4) @(negedge clk);
        chk("second_col", bus.col, 5'b11101);
        cnt  = 4;
        seen = 1'b0;
        while (!seen && cnt < 100) begin
            @(negedge clk);
            cnt++;
            seen = bus.frame_end;
        end
        chk("fe_first", cnt, 20);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 100) begin
            @(negedge clk);
            cnt++;
            seen = bus.frame_end;
        end
        chk("fe_period", cnt, 20);
        chk("fe_col0", bus.col, 5'b11110);

        repeat (5) tick();
        do_req(1, 3'd3, e);
        chk("err1_code3", e, 1'b0);
        @(negedge clk);
        chk("out1_before_edge", bus.out1, 3'd0);
        wait_fe();
        chk("out1_code3", bus.out1, 3'd3);
        chk("out2_blank", bus.out2, 3'd0);

        tick();
        do_req(2, 3'd2, e);
        chk("err2_code2", e, 1'b1);
        wait_fe();
        chk("out2_invalid_kept", bus.out2, 3'd0);
        chk("out1_kept", bus.out1, 3'd3);

        tick();
        do_req(1, 3'd5, e);
        do_req(2, 3'd5, e);
        wait_fe();
        chk("coll1_flag", bus.colisao, 1'b1);
        chk("coll1_out1", bus.out1, 3'd5);
        chk("coll1_out2", bus.out2, 3'd0);
        tick();
        do_req(1, 3'd5, e);
        do_req(2, 3'd5, e);
        wait_fe();
        chk("coll2_flag", bus.colisao, 1'b1);
        chk("coll2_out1", bus.out1, 3'd0);
        chk("coll2_out2", bus.out2, 3'd5);
        tick();
        do_req(1, 3'd3, e);
        wait_fe();
        chk("nocoll_flag", bus.colisao, 1'b0);
        chk("nocoll_out1", bus.out1, 3'd3);
        chk("nocoll_out2", bus.out2, 3'd5);

        tick();
        do_req(1, 3'd4, e);
        tick();
        bus.req1  = 1'b1;
        bus.code1 = 3'd7;
        wait_fe();
        chk("held_ack1", bus.ack1, 1'b0);
        chk("held_out1", bus.out1, 3'd4);
        @(negedge clk);
        chk("late_ack1", bus.ack1, 1'b1);
        chk("late_err1", bus.err1, 1'b0);
        @(posedge clk);
        #1;
        bus.req1 = 1'b0;
        wait_fe();
        chk("out1_code7", bus.out1, 3'd7);

        repeat (FRAME - 1) @(negedge clk);
        bus.req1  = 1'b1;
        bus.code1 = 3'd1;
        @(negedge clk);
        chk("edge_fe", bus.frame_end, 1'b1);
        chk("edge_ack1", bus.ack1, 1'b1);
        chk("edge_out1_old", bus.out1, 3'd7);
        @(posedge clk);
        #1;
        bus.req1 = 1'b0;
        wait_fe();
        chk("edge_out1_new", bus.out1, 3'd1);

        tick();
        do_req(2, 3'd6, e);
        seen = 1'b0;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            @(negedge clk);
            seen = (bus.col == 5'b11011);
        end
        chk("reach_col2", seen, 1'b1);
        rst       = 1'b1;
        bus.req1  = 1'b1;
        bus.code1 = 3'd3;
        @(negedge clk);
        chk("midrst_col", bus.col, 5'b11111);
        chk("midrst_out1", bus.out1, 3'd0);
        chk("midrst_out2", bus.out2, 3'd0);
        chk("midrst_coll", bus.colisao, 1'b0);
        chk("midrst_ack1", bus.ack1, 1'b0);
        rst      = 1'b0;
        bus.req1 = 1'b0;
        wait_fe();
        wait_fe();
        chk("discard_out2", bus.out2, 3'd0);
        chk("discard_out1", bus.out1, 3'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
